// File: rtl/sat_updown_counter.sv
// Saturating/wrapping up-down counter with parallel load, bounded to 0..MAX_VAL_P.
// Define COUNTER_STATUS_EN to add the at_max_o / at_min_o / event_o status outputs.
module sat_updown_counter #(
  parameter int          WIDTH_P    = 8,
  parameter int          SATURATE_P = 1,
  parameter logic [63:0] MAX_VAL_P  = (64'd1 << WIDTH_P) - 64'd1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               load_i,
  input  logic               en_i,
  output logic [WIDTH_P-1:0] count_o
`ifdef COUNTER_STATUS_EN
  ,
  output logic               at_max_o,
  output logic               at_min_o,
  output logic               event_o
`endif
);

  localparam logic [WIDTH_P-1:0] MAX_C = MAX_VAL_P[WIDTH_P-1:0];
  localparam logic [WIDTH_P-1:0] ONE_C = WIDTH_P'(1);

  if (WIDTH_P < 1 || WIDTH_P > 63) begin : g_bad_width
    $error("sat_updown_counter: WIDTH_P out of range");
  end
  if (MAX_VAL_P < 64'd1 || MAX_VAL_P > ((64'd1 << WIDTH_P) - 64'd1)) begin : g_bad_max
    $error("sat_updown_counter: MAX_VAL_P out of range 1..2**WIDTH_P-1");
  end

  logic [WIDTH_P-1:0] count_d;
  logic [WIDTH_P-1:0] count_q;

  // Bounds are tested before the add/subtract, so the register never sees an out-of-range value.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (load_i) begin
        count_d = (data_i > MAX_C) ? MAX_C : data_i;
      end else if (up_i && !down_i) begin
        if (count_q < MAX_C) count_d = count_q + ONE_C;
        else                 count_d = (SATURATE_P != 0) ? MAX_C : '0;
      end else if (down_i && !up_i) begin
        if (count_q != '0)   count_d = count_q - ONE_C;
        else                 count_d = (SATURATE_P != 0) ? '0 : MAX_C;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

`ifdef COUNTER_STATUS_EN
  logic event_d;
  logic event_q;

  // A bound hit is an up/down request arriving at the bound, whether it then clamps or wraps.
  always_comb begin
    event_d = 1'b0;
    if (en_i && !load_i) begin
      event_d = (up_i && !down_i && count_q == MAX_C) ||
                (down_i && !up_i && count_q == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) event_q <= 1'b0;
    else       event_q <= event_d;
  end

  assign at_max_o = (count_q == MAX_C);
  assign at_min_o = (count_q == '0);
  assign event_o  = event_q;
`endif

endmodule

// File: tb/tb_sat_updown_counter.sv
// Directed bench for sat_updown_counter: a saturating and a wrapping instance (MAX=128)
// share the same stimulus and are checked against a hand-computed vector table.
module tb_sat_updown_counter;

  localparam int W   = 8;
  localparam int MAX = 128;

  logic         clk = 1'b0;
  logic         rst, en, load, up, down;
  logic [W-1:0] data;
  logic [W-1:0] count_s, count_w;
`ifdef COUNTER_STATUS_EN
  logic         at_max_s, at_min_s, event_s;
  logic         at_max_w, at_min_w, event_w;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit inv_en = 1'b0;

  always #5 clk = ~clk;

  sat_updown_counter #(.WIDTH_P(W), .SATURATE_P(1), .MAX_VAL_P(64'd128)) u_sat (
    .clk_i(clk), .rst_i(rst), .data_i(data), .up_i(up), .down_i(down),
    .load_i(load), .en_i(en), .count_o(count_s)
`ifdef COUNTER_STATUS_EN
    , .at_max_o(at_max_s), .at_min_o(at_min_s), .event_o(event_s)
`endif
  );

  sat_updown_counter #(.WIDTH_P(W), .SATURATE_P(0), .MAX_VAL_P(64'd128)) u_wrap (
    .clk_i(clk), .rst_i(rst), .data_i(data), .up_i(up), .down_i(down),
    .load_i(load), .en_i(en), .count_o(count_w)
`ifdef COUNTER_STATUS_EN
    , .at_max_o(at_max_w), .at_min_o(at_min_w), .event_o(event_w)
`endif
  );

  typedef struct {
    logic         rst, en, load, up, down;
    logic [W-1:0] data;
    logic [W-1:0] exp_s, exp_w;
    logic         ev_s, ev_w;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic u,
                       input logic d, input logic [W-1:0] dat);
    @(negedge clk);
    rst = r; en = e; load = l; up = u; down = d; data = dat;
    @(posedge clk);
    #1;
  endtask

  // Count must never exceed the bound once out of reset.
  always @(negedge clk) begin
    if (inv_en) begin
      chk("bound_sat",  {31'd0, (count_s <= W'(MAX))}, 32'd1);
      chk("bound_wrap", {31'd0, (count_w <= W'(MAX))}, 32'd1);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0; data = '0;

    vq.push_back('{1, 0, 0, 0, 0, 8'd0,   8'd0,   8'd0,   0, 0});
    vq.push_back('{1, 0, 0, 0, 0, 8'd0,   8'd0,   8'd0,   0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 8'd42,  8'd42,  8'd42,  0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 8'd42,  8'd42,  8'd42,  0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 8'd0,   8'd42,  8'd42,  0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 8'd0,   8'd42,  8'd42,  0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 8'd138, 8'd128, 8'd128, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 8'd0,   8'd0,   8'd0,   0, 0});
    for (int i = 1; i <= 5; i++)
      vq.push_back('{0, 1, 0, 1, 0, 8'd0, W'(i), W'(i), 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 8'd128, 8'd128, 8'd128, 0, 0});
    vq.push_back('{0, 1, 0, 1, 0, 8'd0,   8'd128, 8'd0,   1, 1});
    vq.push_back('{0, 1, 0, 1, 0, 8'd0,   8'd128, 8'd1,   1, 0});
    vq.push_back('{0, 1, 1, 0, 0, 8'd5,   8'd5,   8'd5,   0, 0});
    for (int i = 4; i >= 0; i--)
      vq.push_back('{0, 1, 0, 0, 1, 8'd0, W'(i), W'(i), 0, 0});
    vq.push_back('{0, 1, 0, 0, 1, 8'd0,   8'd0,   8'd128, 1, 1});
    vq.push_back('{0, 0, 1, 0, 0, 8'd7,   8'd0,   8'd128, 0, 0});
    vq.push_back('{0, 1, 0, 1, 1, 8'd0,   8'd0,   8'd128, 0, 0});
    vq.push_back('{0, 1, 0, 1, 0, 8'd0,   8'd1,   8'd0,   0, 1});
    vq.push_back('{1, 1, 0, 1, 0, 8'd0,   8'd0,   8'd0,   0, 0});
    vq.push_back('{0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   0, 0});

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].load, vq[i].up, vq[i].down, vq[i].data);
      if (!vq[i].rst) inv_en = 1'b1;
      chk($sformatf("vec%0d_sat", i),  {24'd0, count_s}, {24'd0, vq[i].exp_s});
      chk($sformatf("vec%0d_wrap", i), {24'd0, count_w}, {24'd0, vq[i].exp_w});
`ifdef COUNTER_STATUS_EN
      chk($sformatf("vec%0d_ev_sat", i),  {31'd0, event_s}, {31'd0, vq[i].ev_s});
      chk($sformatf("vec%0d_ev_wrap", i), {31'd0, event_w}, {31'd0, vq[i].ev_w});
      chk($sformatf("vec%0d_atmax_sat", i), {31'd0, at_max_s}, {31'd0, (vq[i].exp_s == 8'd128)});
      chk($sformatf("vec%0d_atmin_wrap", i), {31'd0, at_min_w}, {31'd0, (vq[i].exp_w == 8'd0)});
`endif
    end

    // No combinational path: a load set up mid-cycle must not show before the edge.
    @(negedge clk);
    rst = 1'b0; en = 1'b1; load = 1'b1; up = 1'b0; down = 1'b0; data = 8'd50;
    #1;
    chk("no_comb_sat",  {24'd0, count_s}, 32'd0);
    chk("no_comb_wrap", {24'd0, count_w}, 32'd0);
    @(posedge clk);
    #1;
    chk("load50_sat",  {24'd0, count_s}, 32'd50);
    chk("load50_wrap", {24'd0, count_w}, 32'd50);

    // Long up run from 0: saturating instance pins at 128, wrapping one goes 130 mod 129 = 1.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 130; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    chk("long_up_sat",  {24'd0, count_s}, 32'd128);
    chk("long_up_wrap", {24'd0, count_w}, 32'd1);
`ifdef COUNTER_STATUS_EN
    chk("long_up_ev_sat",  {31'd0, event_s}, 32'd1);
    chk("long_up_ev_wrap", {31'd0, event_w}, 32'd0);
`endif

    // Held load with data above the bound keeps reloading the clamped value.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);
    chk("load255_sat",  {24'd0, count_s}, 32'd128);
    chk("load255_wrap", {24'd0, count_w}, 32'd128);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_updown_counter.md
Name: sat_updown_counter

Overview:
- Registered up/down counter with parallel load and an upper bound MAX_VAL_P.
- Overflow and underflow either saturate or wrap within the range 0..MAX_VAL_P.
- Generic utility counter used by pixel, line and window bookkeeping in the Sobel datapath.
- Single clock domain, synchronous active-high reset.

Parameters:
- WIDTH_P, 8: counter and data width in bits, >= 1.
- SATURATE_P, 1: 1 = clamp at the bounds; 0 = wrap within 0..MAX_VAL_P.
- MAX_VAL_P, 2**WIDTH_P-1: inclusive upper bound of the count. Legal range 1..2**WIDTH_P-1; elaboration error if out of range.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  WIDTH_P  parallel load value.
- up_i  input  1  increment request.
- down_i  input  1  decrement request.
- load_i  input  1  load request.
- en_i  input  1  global enable.
- count_o  output  WIDTH_P  current count, driven directly from the register.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high.
- Reset: rst_i=1 at a rising edge sets count_o=0, regardless of en_i or any other input. Reset takes effect mid-operation with no exceptions.
- All updates are registered: a change is visible on count_o one cycle after the controlling edge. No combinational path from any input to count_o.
- en_i=0: count holds; load, up and down are all ignored.
- Priority with en_i=1, highest first: load_i, then up/down.
- Load:
  - Next count = min(data_i, MAX_VAL_P), unsigned compare, in both saturating and wrapping modes.
  - Example: MAX=128, data_i=138 -> 128.
  - Holding load_i for several cycles reloads the value each cycle.
- up_i=1, down_i=0:
  - count < MAX_VAL_P -> count+1.
  - count == MAX_VAL_P -> holds MAX_VAL_P if SATURATE_P=1; goes to 0 if SATURATE_P=0.
- down_i=1, up_i=0:
  - count > 0 -> count-1.
  - count == 0 -> holds 0 if SATURATE_P=1; goes to MAX_VAL_P if SATURATE_P=0.
- up_i=1 and down_i=1 together, no load: count holds.
- Neither up nor down nor load: count holds.
- Arithmetic is unsigned, WIDTH_P bits. Bound compares happen before the add/subtract, so no intermediate overflow is ever registered.
- Count never exceeds MAX_VAL_P. Verification asserts count_o <= MAX_VAL_P on every cycle after reset.

Optional Feature:
- Macro: COUNTER_STATUS_EN.
- Defined: adds three outputs, after count_o in the port list:
  - at_max_o (1 bit): combinational, count_o == MAX_VAL_P.
  - at_min_o (1 bit): combinational, count_o == 0.
  - event_o (1 bit): registered one-cycle pulse, asserted the cycle after an up/down request hit a bound, whether it saturated or wrapped. Cleared by reset; 0 when en_i=0.
- Undefined: the three ports do not exist; count behaviour is identical.

Test Plan:
- Reset, load 42: hold rst_i=1 for 2 cycles -> count_o=0; load_i=1, data_i=42 for 2 cycles, then load_i=0 -> count_o=42 and stays 42 with no requests.
- Load clamp: MAX_VAL_P=128, load data_i=138 -> count_o=128.
- Increment with saturation:
  - Load 0, up_i=1 for 5 cycles -> count_o = 1,2,3,4,5 on successive cycles.
  - Load 128, up_i=1 for 2 cycles -> count_o stays 128.
- Decrement with underflow:
  - Load 5, down_i=1 -> count_o = 4,3,2,1,0.
  - One further down cycle -> count_o=0 with SATURATE_P=1; 128 with SATURATE_P=0.
- Enable and conflict: en_i=0 with load_i=1, data_i=7 -> count_o unchanged; en_i=1, up_i=down_i=1 -> count_o unchanged.
- Wrap and reset mid-count:
  - SATURATE_P=0: at count 128, up_i=1 -> 0.
  - Assert rst_i while up_i=1 -> count_o=0 next cycle.
  - With COUNTER_STATUS_EN: event_o pulses for one cycle at the wrap.
